// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared funct3 encodings, FSM state and access-size helpers
//
// Purpose : constants and small decode helpers for the load/store unit.
//           The funct3 encodings are also used by register_file.
// Contents: F3_* load/store funct3 localparams, lsu_state_t, access_size_t,
//           decode_size(), is_misaligned().
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_t;

    // Encodings execute never issues (011, 11x) fall through to a word access.
    function automatic access_size_t decode_size(input logic is_store, input logic [2:0] funct3);
        access_size_t size;
        size = SIZE_WORD;
        if (is_store) begin
            case (funct3)
                F3_SB:   size = SIZE_BYTE;
                F3_SH:   size = SIZE_HALF;
                F3_SW:   size = SIZE_WORD;
                default: size = SIZE_WORD;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: size = SIZE_BYTE;
                F3_LH, F3_LHU: size = SIZE_HALF;
                F3_LW:         size = SIZE_WORD;
                default:       size = SIZE_WORD;
            endcase
        end
        return size;
    endfunction

    function automatic logic is_misaligned(input access_size_t size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            default:   bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, data-memory and writeback bundle of the load/store unit
//
// Purpose : groups the execute request channel, the data-memory channel and
//           the register_file writeback/fault outputs.
// Modports: slave  - the load/store unit itself
//           master - the surrounding pipeline / memory (or a testbench)
interface load_store_unit_if;

    // execute -> LSU
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    // LSU <-> data memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // LSU -> register_file / status
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_load_op;
    logic [31:0] wb_data;
    logic        store_done;
    logic        misalign_fault;
    logic        timeout_fault;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rvalid, mem_rdata,
        output wb_valid, wb_rd, wb_load_op, wb_data,
        output store_done, misalign_fault, timeout_fault
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_rvalid, mem_rdata,
        input  wb_valid, wb_rd, wb_load_op, wb_data,
        input  store_done, misalign_fault, timeout_fault
    );

endinterface

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - combinational byte-lane shifter and strobe generator
//
// Purpose : places store data into its byte lanes with matching strobes, and
//           shifts the addressed lane of a read word down to bit 0.
// Ports   : size       in  access size (byte/half/word)
//           offset     in  byte offset within the word (addr[1:0])
//           store_data in  unshifted store data
//           load_word  in  word returned by memory
//           wstrb      out byte strobes for a store
//           wdata      out lane-replicated store data
//           load_data  out read word shifted so the addressed byte is at bit 0
import load_store_unit_pkg::*;

module load_store_unit_align (
    input  access_size_t size,
    input  logic [1:0]   offset,
    input  logic [31:0]  store_data,
    input  logic [31:0]  load_word,
    output logic [3:0]   wstrb,
    output logic [31:0]  wdata,
    output logic [31:0]  load_data
);

    // Replicating the data into every lane means only the strobes depend on
    // the offset; the memory picks the enabled lanes.
    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (size)
            SIZE_BYTE: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                wstrb = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Upper bits carry the remaining higher lanes (zero-filled); register_file
    // masks or extends them according to the load op.
    assign load_data = load_word >> {offset, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit between execute and register_file
//
// Purpose : accepts one load/store per handshake, issues a word-aligned data
//           memory request with byte strobes, waits for the ack and returns
//           lane-aligned load data or a store completion. Misaligned accesses
//           are rejected without touching memory; missing acks time out.
// Params  : TIMEOUT_CYCLES - cycles spent in WAIT without an ack before abort (1..255)
// Ports   : clk   - clock, all state on the rising edge
//           reset - synchronous, active-high
//           bus   - load_store_unit_if.slave (request, memory, writeback, faults)
import load_store_unit_pkg::*;

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    lsu_state_t  state_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] rdata_q;
    logic [7:0]  timer_q;

    logic        req_ready_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] mem_wdata_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [2:0]  wb_load_op_q;
    logic [31:0] wb_data_q;
    logic        store_done_q;
    logic        misalign_fault_q;
    logic        timeout_fault_q;

    // One shared aligner: in IDLE it looks at the incoming request so the
    // memory outputs can be registered at accept; afterwards it works on the
    // latched access and the captured read word.
    logic         in_idle;
    access_size_t live_size;
    access_size_t held_size;
    access_size_t align_size;
    logic [1:0]   align_offset;
    logic [31:0]  align_store_data;
    logic [3:0]   align_wstrb;
    logic [31:0]  align_wdata;
    logic [31:0]  align_load_data;
    logic         live_misaligned;

    assign in_idle          = (state_q == ST_IDLE);
    assign live_size        = decode_size(bus.req_is_store, bus.req_funct3);
    assign held_size        = decode_size(is_store_q, funct3_q);
    assign align_size       = in_idle ? live_size : held_size;
    assign align_offset     = in_idle ? bus.req_addr[1:0] : addr_lo_q;
    assign align_store_data = in_idle ? bus.req_wdata : wdata_q;
    assign live_misaligned  = is_misaligned(live_size, bus.req_addr[1:0]);

    load_store_unit_align u_align (
        .size       (align_size),
        .offset     (align_offset),
        .store_data (align_store_data),
        .load_word  (rdata_q),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .load_data  (align_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            is_store_q       <= 1'b0;
            funct3_q         <= 3'b000;
            addr_lo_q        <= 2'b00;
            wdata_q          <= 32'h0;
            rd_q             <= 5'd0;
            rdata_q          <= 32'h0;
            timer_q          <= 8'd0;
            req_ready_q      <= 1'b1;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= 32'h0;
            mem_wstrb_q      <= 4'b0000;
            mem_wdata_q      <= 32'h0;
            wb_valid_q       <= 1'b0;
            wb_rd_q          <= 5'd0;
            wb_load_op_q     <= 3'b000;
            wb_data_q        <= 32'h0;
            store_done_q     <= 1'b0;
            misalign_fault_q <= 1'b0;
            timeout_fault_q  <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises the one it owns.
            mem_req_q        <= 1'b0;
            wb_valid_q       <= 1'b0;
            store_done_q     <= 1'b0;
            misalign_fault_q <= 1'b0;
            timeout_fault_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        is_store_q <= bus.req_is_store;
                        funct3_q   <= bus.req_funct3;
                        addr_lo_q  <= bus.req_addr[1:0];
                        wdata_q    <= bus.req_wdata;
                        rd_q       <= bus.req_rd;
                        if (live_misaligned) begin
                            misalign_fault_q <= 1'b1;
                        end else begin
                            state_q     <= ST_ISSUE;
                            req_ready_q <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.req_is_store;
                            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_wstrb_q <= bus.req_is_store ? align_wstrb : 4'b0000;
                            mem_wdata_q <= bus.req_is_store ? align_wdata : 32'h0;
                        end
                    end
                end

                ST_ISSUE: begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= 32'h0;
                    mem_wstrb_q <= 4'b0000;
                    mem_wdata_q <= 32'h0;
                    timer_q     <= 8'd0;
                    state_q     <= ST_WAIT;
                end

                ST_WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    // The ack is checked first so an ack on the last allowed
                    // cycle still completes the access.
                    if (bus.mem_rvalid) begin
                        if (!is_store_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        state_q <= ST_RESP;
                    end else if ((timer_q + 8'd1) == TIMEOUT_LIMIT) begin
                        timeout_fault_q <= 1'b1;
                        state_q         <= ST_IDLE;
                        req_ready_q     <= 1'b1;
                    end
                end

                ST_RESP: begin
                    if (is_store_q) begin
                        store_done_q <= 1'b1;
                    end else begin
                        wb_valid_q   <= 1'b1;
                        wb_rd_q      <= rd_q;
                        wb_load_op_q <= funct3_q;
                        wb_data_q    <= align_load_data;
                    end
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wstrb      = mem_wstrb_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_rd          = wb_rd_q;
    assign bus.wb_load_op     = wb_load_op_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.store_done     = store_done_q;
    assign bus.misalign_fault = misalign_fault_q;
    assign bus.timeout_fault  = timeout_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] ext;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns just after the accept edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        step();
        bus.req_valid    = 1'b0;
    endtask

    // Memory ack for one cycle.
    task automatic ack(input logic [31:0] rdata);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_rd       = 5'd0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = 32'h0;
        step();
        step();

        // reset state
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_faults", {bus.store_done, bus.misalign_fault, bus.timeout_fault}, 0);
        reset = 1'b0;
        step();

        // LW 0x100, ack the cycle after mem_req, wb_valid 3 cycles after accept
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5);
        check("lw_mem_req", bus.mem_req, 1);
        check("lw_mem_addr", bus.mem_addr, 32'h0000_0100);
        check("lw_mem_we_wstrb", {bus.mem_we, bus.mem_wstrb}, 5'b0_0000);
        check("lw_req_ready_busy", bus.req_ready, 0);
        step();
        check("lw_mem_req_pulse", bus.mem_req, 0);
        ack(32'hDEAD_BEEF);
        check("lw_wb_not_yet", bus.wb_valid, 0);
        step();
        check("lw_wb_valid", bus.wb_valid, 1);
        check("lw_wb_data", bus.wb_data, 32'hDEAD_BEEF);
        check("lw_wb_load_op", bus.wb_load_op, 3'b010);
        check("lw_wb_rd", bus.wb_rd, 5'd5);
        check("lw_req_ready_back", bus.req_ready, 1);
        step();
        check("lw_wb_pulse", bus.wb_valid, 0);

        // LB 0x103: top lane down to bit 0, sign-extended as register_file would
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
        check("lb_mem_addr", bus.mem_addr, 32'h0000_0100);
        step();
        ack(32'h8011_2233);
        step();
        check("lb_wb_valid", bus.wb_valid, 1);
        check("lb_wb_byte", bus.wb_data[7:0], 8'h80);
        check("lb_wb_load_op", bus.wb_load_op, 3'b000);
        ext = {{24{bus.wb_data[7]}}, bus.wb_data[7:0]};
        check("lb_sext", ext, 32'hFFFF_FF80);
        step();

        // LH 0x102: upper half down to bit 0
        issue(1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd9);
        step();
        ack(32'hBEEF_1234);
        step();
        check("lh_wb_half", bus.wb_data[15:0], 16'hBEEF);
        check("lh_wb_load_op", bus.wb_load_op, 3'b001);
        step();

        // SH 0x22
        issue(1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 5'd0);
        check("sh_mem_req", bus.mem_req, 1);
        check("sh_mem_we", bus.mem_we, 1);
        check("sh_mem_addr", bus.mem_addr, 32'h0000_0020);
        check("sh_wstrb", bus.mem_wstrb, 4'b1100);
        check("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        step();
        ack(32'h0);
        check("sh_done_not_yet", bus.store_done, 0);
        step();
        check("sh_store_done", bus.store_done, 1);
        check("sh_no_wb", bus.wb_valid, 0);
        step();
        check("sh_done_pulse", bus.store_done, 0);

        // SB 0x01
        issue(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 5'd0);
        check("sb_wstrb", bus.mem_wstrb, 4'b0010);
        check("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        step();
        ack(32'h0);
        step();
        check("sb_store_done", bus.store_done, 1);
        step();

        // SW 0x40
        issue(1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678, 5'd0);
        check("sw_wstrb", bus.mem_wstrb, 4'b1111);
        check("sw_wdata", bus.mem_wdata, 32'h1234_5678);
        step();
        ack(32'h0);
        step();
        check("sw_store_done", bus.store_done, 1);
        step();

        // LW 0x101 misaligned: fault pulse, no memory request
        issue(1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3);
        check("mis_lw_fault", bus.misalign_fault, 1);
        check("mis_lw_no_req", bus.mem_req, 0);
        check("mis_lw_ready", bus.req_ready, 1);
        step();
        check("mis_lw_pulse", bus.misalign_fault, 0);
        check("mis_lw_still_no_req", bus.mem_req, 0);

        // LH 0x103 misaligned
        issue(1'b0, 3'b001, 32'h0000_0103, 32'h0, 5'd3);
        check("mis_lh_fault", bus.misalign_fault, 1);
        check("mis_lh_no_req", bus.mem_req, 0);
        step();

        // No ack: 4 cycles in WAIT, then timeout pulse and no writeback
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd4);
        check("to_mem_req", bus.mem_req, 1);
        step();
        step();
        check("to_wait1", bus.timeout_fault, 0);
        step();
        check("to_wait2", bus.timeout_fault, 0);
        step();
        check("to_wait3", bus.timeout_fault, 0);
        step();
        check("to_fault", bus.timeout_fault, 1);
        check("to_no_wb", bus.wb_valid, 0);
        check("to_ready", bus.req_ready, 1);
        step();
        check("to_fault_pulse", bus.timeout_fault, 0);

        // next request after timeout is accepted and completes
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd6);
        check("post_to_mem_req", bus.mem_req, 1);
        check("post_to_mem_addr", bus.mem_addr, 32'h0000_0300);
        step();
        ack(32'h0BAD_F00D);
        step();
        check("post_to_wb", bus.wb_data, 32'h0BAD_F00D);
        step();

        // ack on the last allowed WAIT cycle wins over the timeout
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd8);
        step();
        step();
        step();
        step();
        ack(32'h5555_AAAA);
        check("ackwin_no_fault", bus.timeout_fault, 0);
        step();
        check("ackwin_wb_valid", bus.wb_valid, 1);
        check("ackwin_wb_data", bus.wb_data, 32'h5555_AAAA);
        step();

        // reset during WAIT, then a stray ack
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ack(32'hFFFF_FFFF);
        check("rstw_no_wb", bus.wb_valid, 0);
        check("rstw_ready", bus.req_ready, 1);
        step();
        check("rstw_no_wb_late", bus.wb_valid, 0);
        check("rstw_no_req", bus.mem_req, 0);
        check("rstw_no_fault", {bus.store_done, bus.misalign_fault, bus.timeout_fault}, 0);
        check("rstw_wb_data", bus.wb_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
